// File: rtl/raster_tile_walker_pkg.sv
// Shared widths, walker state encoding and the edge-extent helper for raster_tile_walker.
// Widths come from the VX_RASTER_PID_BITS / VX_RASTER_DIM_BITS / RASTER_DATA_BITS macros when the build provides them.
`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

package raster_tile_walker_pkg;

    localparam int PID_BITS  = `VX_RASTER_PID_BITS;
    localparam int DIM_BITS  = `VX_RASTER_DIM_BITS;
    localparam int DATA_BITS = `RASTER_DATA_BITS;

    typedef logic [DATA_BITS-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WALK  = 2'd2
    } walker_state_e;

    // max(value, 0) * (2^log_size - 1), built as (value << log_size) - value
    function automatic data_t edge_extent(input data_t value, input int unsigned log_size);
        if ($signed(value) > 0) begin
            return (value << log_size) - value;
        end
        return '0;
    endfunction

endpackage

// File: rtl/raster_tile_walker_edge_stepper.sv
// One edge function of the tile walker: tracks the row-start and current block-origin values
// and flags whether the block can touch the edge's positive half-plane.
module raster_tile_walker_edge_stepper
    import raster_tile_walker_pkg::*;
#(
    parameter int BLOCK_LOGSIZE = 2
) (
    input  logic  clk,
    input  logic  setup,
    input  logic  step,
    input  logic  row_end,
    input  data_t a,
    input  data_t b,
    input  data_t c,
    output data_t cur_e,
    output logic  overlap
);

    data_t row_e;
    data_t extent;
    data_t a_step;
    data_t b_step;
    data_t reach;

    assign a_step = a << BLOCK_LOGSIZE;
    assign b_step = b << BLOCK_LOGSIZE;

    // NOTE: pure datapath registers carry no reset; SETUP always reloads them before they are read.
    always_ff @(posedge clk) begin
        if (setup) begin
            extent <= edge_extent(a, BLOCK_LOGSIZE) + edge_extent(b, BLOCK_LOGSIZE);
            row_e  <= c;
            cur_e  <= c;
        end else if (step) begin
            if (row_end) begin
                row_e <= row_e + b_step;
                cur_e <= row_e + b_step;
            end else begin
                cur_e <= cur_e + a_step;
            end
        end
    end

    // Best corner of the block is cur_e + extent; non-negative means possible coverage
    assign reach   = cur_e + extent;
    assign overlap = ~reach[DATA_BITS-1];

endmodule

// File: rtl/raster_tile_walker.sv
// Walks a tile's blocks in raster order, one per cycle, emitting blocks that overlap the primitive.
// Optional whole-tile rejection in SETUP is enabled by defining RASTER_WALKER_TILE_REJECT_EN.
module raster_tile_walker
    import raster_tile_walker_pkg::*;
#(
    parameter string INSTANCE_ID   = "",
    parameter int    TILE_LOGSIZE  = 5,
    parameter int    BLOCK_LOGSIZE = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid_in,
    output logic                               ready_in,
    input  logic [PID_BITS-1:0]                pid_in,
    input  logic [DIM_BITS-1:0]                xloc_in,
    input  logic [DIM_BITS-1:0]                yloc_in,
    input  logic [2:0][2:0][DATA_BITS-1:0]     edges_in,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic [PID_BITS-1:0]                pid_out,
    output logic [DIM_BITS-1:0]                xloc_out,
    output logic [DIM_BITS-1:0]                yloc_out,
    output logic [2:0][2:0][DATA_BITS-1:0]     edges_out,
    output logic                               busy
);

    localparam int CNT_W = (TILE_LOGSIZE > BLOCK_LOGSIZE) ? TILE_LOGSIZE - BLOCK_LOGSIZE : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << (TILE_LOGSIZE - BLOCK_LOGSIZE)) - 1);
    localparam string unused_instance_id = INSTANCE_ID;

    walker_state_e state;
    walker_state_e next_state;

    logic                           setup;
    logic                           walk_en;
    logic                           accept;
    logic                           row_end;
    logic                           last_block;
    logic                           block_hit;
    logic [CNT_W-1:0]               bx;
    logic [CNT_W-1:0]               by;
    logic [DIM_BITS-1:0]            x_off;
    logic [DIM_BITS-1:0]            y_off;
    logic [PID_BITS-1:0]            pid_r;
    logic [DIM_BITS-1:0]            xloc_r;
    logic [DIM_BITS-1:0]            yloc_r;
    logic [2:0][2:0][DATA_BITS-1:0] edges_r;
    data_t                          cur_e [3];
    logic [2:0]                     overlap;

    assign accept     = valid_in && ready_in;
    assign row_end    = (bx == LAST_IDX);
    assign last_block = row_end && (by == LAST_IDX);
    assign block_hit  = &overlap;
    assign x_off      = DIM_BITS'(bx) << BLOCK_LOGSIZE;
    assign y_off      = DIM_BITS'(by) << BLOCK_LOGSIZE;
    assign busy       = (state != ST_IDLE) || valid_out;

`ifdef RASTER_WALKER_TILE_REJECT_EN
    data_t tile_reach [3];
    logic  tile_pass;

    always_comb begin
        tile_pass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tile_reach[i] = edges_r[i][2] + edge_extent(edges_r[i][0], TILE_LOGSIZE)
                          + edge_extent(edges_r[i][1], TILE_LOGSIZE);
            if (tile_reach[i][DATA_BITS-1]) begin
                tile_pass = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (valid_in) next_state = ST_SETUP;
`ifdef RASTER_WALKER_TILE_REJECT_EN
            ST_SETUP: next_state = tile_pass ? ST_WALK : ST_IDLE;
`else
            ST_SETUP: next_state = ST_WALK;
`endif
            ST_WALK:  if (walk_en && last_block) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_in = 1'b0;
        setup    = 1'b0;
        walk_en  = 1'b0;
        case (state)
            ST_IDLE:  ready_in = 1'b1;
            ST_SETUP: setup    = 1'b1;
            ST_WALK:  walk_en  = ~valid_out || ready_out;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pid_r   <= pid_in;
            xloc_r  <= xloc_in;
            yloc_r  <= yloc_in;
            edges_r <= edges_in;
        end
    end

    always_ff @(posedge clk) begin
        if (setup) begin
            bx <= '0;
            by <= '0;
        end else if (walk_en) begin
            if (row_end) begin
                bx <= '0;
                by <= by + CNT_W'(1);
            end else begin
                bx <= bx + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_edge
        raster_tile_walker_edge_stepper #(
            .BLOCK_LOGSIZE (BLOCK_LOGSIZE)
        ) u_stepper (
            .clk     (clk),
            .setup   (setup),
            .step    (walk_en),
            .row_end (row_end),
            .a       (edges_r[i][0]),
            .b       (edges_r[i][1]),
            .c       (edges_r[i][2]),
            .cur_e   (cur_e[i]),
            .overlap (overlap[i])
        );
    end

    // Single-entry output register: a new load wins over a drain in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
        end else if (walk_en && block_hit) begin
            valid_out <= 1'b1;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (walk_en && block_hit) begin
            pid_out  <= pid_r;
            xloc_out <= xloc_r + x_off;
            yloc_out <= yloc_r + y_off;
            for (int i = 0; i < 3; i++) begin
                edges_out[i][0] <= edges_r[i][0];
                edges_out[i][1] <= edges_r[i][1];
                edges_out[i][2] <= cur_e[i];
            end
        end
    end

endmodule

// File: tb/tb_raster_tile_walker.sv
// Scoreboard bench for raster_tile_walker: a direct edge-function model predicts emitted blocks,
// a monitor compares them as they fire and checks hold-stability during stalls.
module tb_raster_tile_walker;
    import raster_tile_walker_pkg::*;

    localparam int TL = 5;
    localparam int BL = 2;
    localparam int S  = 1 << BL;
    localparam int N  = 1 << (TL - BL);
`ifdef RASTER_WALKER_TILE_REJECT_EN
    localparam int REJECT_LAT = 2;
`else
    localparam int REJECT_LAT = N * N + 2;
`endif

    typedef struct packed {
        logic [PID_BITS-1:0]            pid;
        logic [DIM_BITS-1:0]            x;
        logic [DIM_BITS-1:0]            y;
        logic [2:0][2:0][DATA_BITS-1:0] edges;
    } blk_t;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           valid_in;
    logic                           ready_in;
    logic [PID_BITS-1:0]            pid_in;
    logic [DIM_BITS-1:0]            xloc_in;
    logic [DIM_BITS-1:0]            yloc_in;
    logic [2:0][2:0][DATA_BITS-1:0] edges_in;
    logic                           valid_out;
    logic                           ready_out;
    logic [PID_BITS-1:0]            pid_out;
    logic [DIM_BITS-1:0]            xloc_out;
    logic [DIM_BITS-1:0]            yloc_out;
    logic [2:0][2:0][DATA_BITS-1:0] edges_out;
    logic                           busy;

    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    int   rmode = 0;
    time  last_pop_time = 0;
    blk_t exp_q [$];

    always #5 clk = ~clk;

    raster_tile_walker #(
        .INSTANCE_ID   ("tb"),
        .TILE_LOGSIZE  (TL),
        .BLOCK_LOGSIZE (BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .pid_in    (pid_in),
        .xloc_in   (xloc_in),
        .yloc_in   (yloc_in),
        .edges_in  (edges_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .pid_out   (pid_out),
        .xloc_out  (xloc_out),
        .yloc_out  (yloc_out),
        .edges_out (edges_out),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: evaluate every edge directly at each block origin and keep blocks whose best corner is >= 0
    function automatic void push_expected(input blk_t rec);
        blk_t o;
        bit   hit;
        int   a, b, c, e, ext;
        for (int by = 0; by < N; by++) begin
            for (int bx = 0; bx < N; bx++) begin
                hit   = 1'b1;
                o.pid = rec.pid;
                o.x   = rec.x + DIM_BITS'(bx * S);
                o.y   = rec.y + DIM_BITS'(by * S);
                for (int i = 0; i < 3; i++) begin
                    a   = rec.edges[i][0];
                    b   = rec.edges[i][1];
                    c   = rec.edges[i][2];
                    e   = c + a * (bx * S) + b * (by * S);
                    ext = (a > 0 ? a : 0) * (S - 1) + (b > 0 ? b : 0) * (S - 1);
                    if (e + ext < 0) hit = 1'b0;
                    o.edges[i][0] = a;
                    o.edges[i][1] = b;
                    o.edges[i][2] = e;
                end
                if (hit) exp_q.push_back(o);
            end
        end
    endfunction

    function automatic blk_t make_rec(input int pid, input int x, input int y,
                                      input int a0, input int b0, input int c0,
                                      input int a1, input int b1, input int c1,
                                      input int a2, input int b2, input int c2);
        blk_t r;
        r.pid = PID_BITS'(pid);
        r.x   = DIM_BITS'(x);
        r.y   = DIM_BITS'(y);
        r.edges[0][0] = a0; r.edges[0][1] = b0; r.edges[0][2] = c0;
        r.edges[1][0] = a1; r.edges[1][1] = b1; r.edges[1][2] = c1;
        r.edges[2][0] = a2; r.edges[2][1] = b2; r.edges[2][2] = c2;
        return r;
    endfunction

    // Presents a record and returns the time of the posedge at which it was accepted
    task automatic send(input blk_t rec, output time t_fire);
        int waited;
        @(negedge clk);
        valid_in = 1'b1;
        pid_in   = rec.pid;
        xloc_in  = rec.x;
        yloc_in  = rec.y;
        edges_in = rec.edges;
        waited   = 0;
        while (!ready_in && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_in) check("accept_timeout", ready_in, 1'b1);
        push_expected(rec);
        @(posedge clk);
        t_fire = $time;
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || busy) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Number of the cycle (relative to the accept cycle t) whose negedge is at time t_now
    function automatic int cyc_of(input time t_now, input time t_fire);
        return int'((t_now - t_fire + 5) / 10);
    endfunction

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready_out = 1'b1;
                1:       ready_out = ~ready_out;
                default: ready_out = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare every fired output against the head of the scoreboard
    logic hold_pending = 1'b0;
    blk_t held;
    blk_t got;
    blk_t want;
    always @(negedge clk) begin
        got.pid   = pid_out;
        got.x     = xloc_out;
        got.y     = yloc_out;
        got.edges = edges_out;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) check("hold_stable", {valid_out, got}, {1'b1, held});
            hold_pending = valid_out && !ready_out;
            held         = got;
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", valid_out, 1'b0);
                end else begin
                    want = exp_q.pop_front();
                    check("block", got, want);
                end
                n_out++;
                last_pop_time = $time;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t rec;
        time  t_fire, t_fire2;
        int   base, m;

        reset    = 1'b1;
        valid_in = 1'b0;
        pid_in   = '0;
        xloc_in  = '0;
        yloc_in  = '0;
        edges_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid_out", valid_out, 1'b0);
        check("reset_ready_in", ready_in, 1'b1);
        check("reset_busy", busy, 1'b0);
        #1 reset = 1'b0;

        // Full cover: 64 blocks, last one visible at t+66
        rmode = 0;
        base  = n_out;
        rec   = make_rec(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        drain();
        check("full_count", n_out - base, N * N);
        check("full_last_cycle", cyc_of(last_pop_time, t_fire), N * N + 2);

        // Half-plane: only bx 0..3 survive on each row
        base = n_out;
        rec  = make_rec(2, 0, 0, -1, 0, 15, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        drain();
        check("half_count", n_out - base, 32);

        // Full reject: nothing emitted, ready_in returns at the configured latency
        base = n_out;
        rec  = make_rec(3, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!ready_in && m < 200);
        check("reject_ready_cycle", m, REJECT_LAT);
        drain();
        check("reject_count", n_out - base, 0);

        // Backpressure: ready_out toggles every cycle
        rmode = 1;
        base  = n_out;
        rec   = make_rec(4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        drain();
        check("bp_count", n_out - base, N * N);
        rmode = 0;

        // Offset origin and back-to-back acceptance
        base = n_out;
        rec  = make_rec(5, 64, 96, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        rec  = make_rec(6, 64, 96, 1, 1, -3, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire2);
        check("b2b_accept_gap", int'((t_fire2 - t_fire) / 10), N * N + 2);
        drain();

        // Reset while block 10 is being evaluated
        base = n_out;
        rec  = make_rec(7, 32, 32, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        repeat (12) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_valid_out", valid_out, 1'b0);
        check("midreset_ready_in", ready_in, 1'b1);
        check("midreset_emitted", n_out - base, 10);
        exp_q.delete();
        #1 reset = 1'b0;
        base = n_out;
        rec  = make_rec(8, 160, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1);
        send(rec, t_fire);
        drain();
        check("post_reset_count", n_out - base, N * N);

        // Randomized primitives with random backpressure
        rmode = 2;
        for (int k = 0; k < 12; k++) begin
            rec.pid = PID_BITS'($urandom);
            rec.x   = DIM_BITS'($urandom_range(0, 63) * 32);
            rec.y   = DIM_BITS'($urandom_range(0, 63) * 32);
            for (int i = 0; i < 3; i++) begin
                rec.edges[i][0] = int'($urandom_range(0, 12)) - 6;
                rec.edges[i][1] = int'($urandom_range(0, 12)) - 6;
                rec.edges[i][2] = int'($urandom_range(0, 180)) - 60;
            end
            send(rec, t_fire);
        end
        drain();
        rmode = 0;

        @(negedge clk);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
